// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state/owner encodings and small helpers for the RAM-port arbiter.
// Byte-count and load-extension helpers are shared by the arbiter and its users.
package mem_arbiter_pkg;

  localparam logic [31:0] IO_BASE   = 32'h0003_0000;
  localparam logic [1:0]  REQUIRE8  = 2'd0;
  localparam logic [1:0]  REQUIRE16 = 2'd1;
  localparam logic [1:0]  REQUIRE32 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_IF,
    OWN_LD,
    OWN_ST
  } owner_e;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      REQUIRE8:  return 3'd1;
      REQUIRE16: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // IO space is selected by address bits [17:16] alone.
  function automatic logic is_io(input logic [1:0] seg);
    return seg == IO_BASE[17:16];
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] n,
                                              input logic sgn);
    case (n)
      3'd1:    return {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the arbiter; master is the arbiter,
// slave is the fetch unit / LSB / RAM environment around it.
interface mem_arbiter_if;

  logic        rdy;
  logic        jump_wrong;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_read;
  logic        lsb_write;
  logic [1:0]  lsb_len;
  logic        lsb_signed;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_load_done;
  logic        lsb_store_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  rdy, jump_wrong, if_req, if_addr, lsb_read, lsb_write, lsb_len, lsb_signed,
           lsb_addr, lsb_wdata, mem_din, io_buffer_full,
    output if_done, if_data, lsb_load_done, lsb_store_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output rdy, jump_wrong, if_req, if_addr, lsb_read, lsb_write, lsb_len, lsb_signed,
           lsb_addr, lsb_wdata, mem_din, io_buffer_full,
    input  if_done, if_data, lsb_load_done, lsb_store_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serializes fetch and load/store requests onto the byte-wide RAM port, reassembling
// little-endian read data; speculative reads abort on mispredict, stores always finish.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus_io
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        lsb_last_q, lsb_last_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  issue_q, issue_d;
  logic [2:0]  cap_q, cap_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic        sgn_q, sgn_d;

  logic [31:0] cur_addr;
  logic        flush;
  logic        lsb_pend;
  logic        pick_if;

  assign cur_addr = base_q + {29'd0, issue_q};
  assign flush    = bus_io.jump_wrong && (owner_q != OWN_ST);
  assign lsb_pend = bus_io.lsb_read | bus_io.lsb_write;
  // On a tie, fetch wins only if the LSB was served last.
  assign pick_if  = bus_io.if_req && (!lsb_pend || lsb_last_q);

  assign bus_io.if_data   = asm_q;
  assign bus_io.lsb_rdata = extend_load(asm_q, n_q, sgn_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      lsb_last_q <= 1'b1;
      n_q        <= 3'd0;
      issue_q    <= 3'd0;
      cap_q      <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      sgn_q      <= 1'b0;
    end else if (bus_io.rdy) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lsb_last_q <= lsb_last_d;
      n_q        <= n_d;
      issue_q    <= issue_d;
      cap_q      <= cap_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      sgn_q      <= sgn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lsb_last_d = lsb_last_q;
    n_d        = n_q;
    issue_d    = issue_q;
    cap_d      = cap_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    sgn_d      = sgn_q;
    bus_io.mem_a          = 32'd0;
    bus_io.mem_dout       = 8'd0;
    bus_io.mem_wr         = 1'b0;
    bus_io.if_done        = 1'b0;
    bus_io.lsb_load_done  = 1'b0;
    bus_io.lsb_store_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus_io.jump_wrong && (bus_io.if_req || lsb_pend)) begin
          state_d = ST_RUN;
          issue_d = 3'd0;
          cap_d   = 3'd0;
          asm_d   = 32'd0;
          if (pick_if) begin
            owner_d = OWN_IF;
            base_d  = bus_io.if_addr;
            n_d     = 3'd4;
            sgn_d   = 1'b0;
          end else begin
            owner_d = bus_io.lsb_write ? OWN_ST : OWN_LD;
            base_d  = bus_io.lsb_addr;
            n_d     = len_bytes(bus_io.lsb_len);
            wdata_d = bus_io.lsb_wdata;
            sgn_d   = bus_io.lsb_signed;
          end
        end
      end

      ST_RUN: begin
        if (owner_q == OWN_ST) begin
          // A full IO buffer holds the current byte back without advancing.
          if (issue_q < n_q && !(is_io(cur_addr[17:16]) && bus_io.io_buffer_full)) begin
            bus_io.mem_a    = cur_addr;
            bus_io.mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
            bus_io.mem_wr   = 1'b1;
            issue_d         = issue_q + 3'd1;
            if (issue_q == n_q - 3'd1) state_d = ST_DONE;
          end
        end else begin
          if (issue_q < n_q) begin
            bus_io.mem_a = cur_addr;
            issue_d      = issue_q + 3'd1;
          end
          // RAM data lags the address by one cycle, so capture trails issue.
          if (cap_q < issue_q) begin
            asm_d[{cap_q[1:0], 3'b000} +: 8] = bus_io.mem_din;
            cap_d = cap_q + 3'd1;
            if (cap_q == n_q - 3'd1) state_d = ST_DONE;
          end
          if (bus_io.jump_wrong) state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush) begin
          bus_io.if_done        = (owner_q == OWN_IF);
          bus_io.lsb_load_done  = (owner_q == OWN_LD);
          bus_io.lsb_store_done = (owner_q == OWN_ST);
          lsb_last_d            = (owner_q != OWN_IF);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a byte RAM device and an
// arithmetic reference model of memory contents, latencies and arbitration order.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ram    [logic [31:0]];
  logic [7:0]  refMem [logic [31:0]];
  logic [31:0] aLog   [0:63];

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wrQ[$];

  // RAM device: frozen by rdy, read data appears one cycle after the address.
  always @(posedge clk) begin
    if (bus.rdy) begin
      if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
      bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]    = d;
    refMem[a] = d;
  endtask

  function automatic logic [7:0] refRd(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input int n, input logic sgn);
    longint val = 0;
    for (int i = 0; i < n; i++) val += longint'(refRd(a + 32'(i))) << (8 * i);
    if (sgn && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
    return 32'(val);
  endfunction

  function automatic int bytesOf(input int kind, input logic [1:0] len);
    if (kind == 0) return 4;
    return (len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4);
  endfunction

  task automatic dropReqs();
    bus.if_req    = 1'b0;
    bus.lsb_read  = 1'b0;
    bus.lsb_write = 1'b0;
  endtask

  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] len,
                               input logic sgn, input logic [31:0] wdata);
    bus.if_req     = (kind == 0);
    bus.if_addr    = (kind == 0) ? addr : $urandom;
    bus.lsb_read   = (kind == 1);
    bus.lsb_write  = (kind == 2);
    bus.lsb_addr   = addr;
    bus.lsb_len    = len;
    bus.lsb_signed = sgn;
    bus.lsb_wdata  = wdata;
  endtask

  // kind: 0 fetch, 1 load, 2 store. jwAt < 0 means no mispredict pulse.
  task automatic doTxn(input string tag, input int kind, input logic [31:0] addr,
                       input logic [1:0] len, input logic sgn, input logic [31:0] wdata,
                       input int jwAt, input int ioFull, input bit randRdy);
    int          n, doneK, active, activeAtDone, doneCnt, wrongDone;
    logic [31:0] gotData;
    logic        myDone, otherDone;
    bit          flushed;
    wr_t         w;
    n = bytesOf(kind, len);
    flushed = (jwAt >= 0) && (kind != 2);
    wrQ.delete();
    doneK = -1; active = 0; activeAtDone = 0; doneCnt = 0; wrongDone = 0; gotData = 32'd0;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) applyStimulus(kind, addr, len, sgn, wdata);
      if (flushed && k == jwAt + 1) dropReqs();
      bus.rdy            = (k == 0 || !randRdy) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.jump_wrong     = (k == jwAt);
      bus.io_buffer_full = (k >= 1 && k <= ioFull);
      #2;
      aLog[k] = bus.mem_a;
      if (flushed && k == jwAt + 1) begin
        checkOutput({tag, " mem_a after flush"}, bus.mem_a, 32'd0);
        checkOutput({tag, " mem_wr after flush"}, 32'(bus.mem_wr), 32'd0);
      end
      case (kind)
        0:       begin myDone = bus.if_done;        otherDone = bus.lsb_load_done | bus.lsb_store_done; end
        1:       begin myDone = bus.lsb_load_done;  otherDone = bus.if_done | bus.lsb_store_done; end
        default: begin myDone = bus.lsb_store_done; otherDone = bus.if_done | bus.lsb_load_done; end
      endcase
      if (bus.rdy) begin
        if (bus.mem_wr) begin
          w.k = k; w.a = bus.mem_a; w.d = bus.mem_dout;
          wrQ.push_back(w);
        end
        if (myDone) begin
          if (doneK < 0) begin
            doneK = k;
            activeAtDone = active;
            gotData = (kind == 0) ? bus.if_data : bus.lsb_rdata;
          end
          doneCnt++;
        end
        if (otherDone) wrongDone++;
        active++;
      end
      if (!flushed && doneK >= 0) break;
      if (flushed && k >= 12) break;
      tick();
    end
    checkOutput({tag, " foreign done"}, 32'(wrongDone), 32'd0);
    if (flushed) begin
      checkOutput({tag, " done after flush"}, 32'(doneCnt), 32'd0);
    end else begin
      checkOutput({tag, " done seen"}, 32'(doneK >= 0), 32'd1);
      if (doneK >= 0) begin
        checkOutput({tag, " latency"}, 32'(activeAtDone),
                    32'((kind == 2) ? n + 1 + ioFull : n + 2));
        if (kind == 2) begin
          checkOutput({tag, " write count"}, 32'(wrQ.size()), 32'(n));
          for (int i = 0; i < n && i < wrQ.size(); i++) begin
            checkOutput({tag, " write addr"}, wrQ[i].a, addr + 32'(i));
            checkOutput({tag, " write byte"}, 32'(wrQ[i].d), 32'((wdata >> (8 * i)) & 32'hFF));
            if (!randRdy) checkOutput({tag, " write cycle"}, 32'(wrQ[i].k), 32'(ioFull + 1 + i));
          end
          for (int i = 0; i < n; i++) refMem[addr + 32'(i)] = 8'((wdata >> (8 * i)) & 32'hFF);
        end else begin
          checkOutput({tag, " data"}, gotData, refLoad(addr, n, (kind == 1) ? sgn : 1'b0));
          checkOutput({tag, " read wrote"}, 32'(wrQ.size()), 32'd0);
          if (!randRdy)
            for (int i = 0; i < n; i++)
              checkOutput({tag, " read addr"}, aLog[i + 1], addr + 32'(i));
        end
      end
    end
    tick();
    dropReqs();
    bus.rdy = 1'b1; bus.jump_wrong = 1'b0; bus.io_buffer_full = 1'b0;
    #2;
    checkOutput({tag, " done width"},
                32'({bus.if_done, bus.lsb_load_done, bus.lsb_store_done}), 32'd0);
    tick();
  endtask

  // Fetch and load requested in the same cycle; the first grant follows round-robin.
  task automatic doPair(input string tag, input logic [31:0] fAddr, input logic [31:0] lAddr,
                        input logic [1:0] len, input logic sgn, input bit expectIfFirst);
    int          ifK, ldK, nL;
    logic [31:0] ifData, ldData;
    nL = bytesOf(1, len);
    ifK = -1; ldK = -1; ifData = 32'd0; ldData = 32'd0;
    bus.if_req = 1'b1; bus.if_addr = fAddr;
    bus.lsb_read = 1'b1; bus.lsb_write = 1'b0; bus.lsb_addr = lAddr;
    bus.lsb_len = len; bus.lsb_signed = sgn;
    bus.rdy = 1'b1; bus.jump_wrong = 1'b0; bus.io_buffer_full = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (bus.if_done && ifK < 0) begin ifK = k; ifData = bus.if_data; end
      if (bus.lsb_load_done && ldK < 0) begin ldK = k; ldData = bus.lsb_rdata; end
      if (ifK >= 0 && ldK >= 0) break;
      tick();
      if (ifK >= 0) bus.if_req = 1'b0;
      if (ldK >= 0) bus.lsb_read = 1'b0;
    end
    checkOutput({tag, " both done"}, 32'(ifK >= 0 && ldK >= 0), 32'd1);
    checkOutput({tag, " fetch first"}, 32'(ifK < ldK), 32'(expectIfFirst));
    checkOutput({tag, " fetch data"}, ifData, refLoad(fAddr, 4, 1'b0));
    checkOutput({tag, " load data"}, ldData, refLoad(lAddr, nL, sgn));
    if (expectIfFirst) checkOutput({tag, " second latency"}, 32'(ldK), 32'(ifK + 1 + nL + 2));
    else               checkOutput({tag, " second latency"}, 32'(ifK), 32'(ldK + 1 + 4 + 2));
    tick();
    dropReqs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.jump_wrong = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_addr = 32'd0; bus.lsb_addr = 32'd0; bus.lsb_len = 2'd0;
    bus.lsb_signed = 1'b0; bus.lsb_wdata = 32'd0;
    dropReqs();

    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    poke(32'h20, 8'h80);
    poke(32'h22, 8'h34); poke(32'h23, 8'hF2);
    poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
    poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    for (int a = 32'h400; a < 32'h500; a++) poke(32'(a), 8'($urandom));

    tick(); tick(); tick();
    #2;
    checkOutput("reset mem_a", bus.mem_a, 32'd0);
    checkOutput("reset strobes",
                32'({bus.mem_wr, bus.if_done, bus.lsb_load_done, bus.lsb_store_done, bus.mem_dout}),
                32'd0);
    checkOutput("reset if_data", bus.if_data, 32'd0);
    checkOutput("reset lsb_rdata", bus.lsb_rdata, 32'd0);
    tick();
    rst = 1'b0;

    $display("[TB] arbitration at reset exit");
    doPair("pair reset", 32'h1000, 32'h20, 2'd0, 1'b1, 1'b1);
    checkOutput("fetch word 0x1000", refLoad(32'h1000, 4, 1'b0), 32'h0000_0513);

    $display("[TB] directed fetch and loads");
    doTxn("fetch 0x1000", 0, 32'h1000, 2'd2, 1'b0, 32'd0, -1, 0, 1'b0);
    doPair("pair after fetch", 32'h1000, 32'h22, 2'd1, 1'b1, 1'b0);
    doTxn("LB 0x20", 1, 32'h20, 2'd0, 1'b1, 32'd0, -1, 0, 1'b0);
    checkOutput("LB model", refLoad(32'h20, 1, 1'b1), 32'hFFFF_FF80);
    doTxn("LBU 0x20", 1, 32'h20, 2'd0, 1'b0, 32'd0, -1, 0, 1'b0);
    doTxn("LH 0x22", 1, 32'h22, 2'd1, 1'b1, 32'd0, -1, 0, 1'b0);
    checkOutput("LH model", refLoad(32'h22, 2, 1'b1), 32'hFFFF_F234);

    $display("[TB] stores, IO stall, flush, wrap");
    doTxn("SW 0x100", 2, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, -1, 0, 1'b0);
    doTxn("LW 0x100", 1, 32'h100, 2'd2, 1'b0, 32'd0, -1, 0, 1'b0);
    doTxn("SB IO", 2, 32'h0003_0000, 2'd0, 1'b0, 32'h1234_565A, -1, 3, 1'b0);
    doTxn("fetch flush", 0, 32'h1000, 2'd2, 1'b0, 32'd0, 2, 0, 1'b0);
    doTxn("SW flush", 2, 32'h104, 2'd2, 1'b0, 32'hCAFE_F00D, 2, 0, 1'b0);
    doTxn("LW 0x104", 1, 32'h104, 2'd2, 1'b0, 32'd0, -1, 0, 1'b0);
    doTxn("fetch wrap", 0, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'd0, -1, 0, 1'b0);

    $display("[TB] reset during a store");
    doTxn("fetch pre-reset", 0, 32'h1000, 2'd2, 1'b0, 32'd0, -1, 0, 1'b0);
    applyStimulus(2, 32'h700, 2'd2, 1'b0, 32'h1122_3344);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dropReqs();
    #2;
    checkOutput("reset mid store mem_wr", 32'(bus.mem_wr), 32'd0);
    checkOutput("reset mid store mem_a", bus.mem_a, 32'd0);
    tick();
    doPair("pair after reset", 32'h1000, 32'h20, 2'd0, 1'b0, 1'b1);

    $display("[TB] randomized traffic with rdy stalls");
    for (int t = 0; t < 40; t++) begin
      int          kind;
      logic [1:0]  len;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      len  = 2'($urandom_range(0, 2));
      addr = 32'h400 + 32'($urandom_range(0, 252));
      doTxn($sformatf("rand%0d k%0d", t, kind), kind, addr, len, 1'($urandom), $urandom,
            -1, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
